// File: rtl/alu_mutation_tester.sv
// ---------------------------------------------------------------------------
// alu_mutation_tester
//
// Stimulus/response engine for mutation testing of a 4-bit combinational ALU.
// It sweeps all 2048 {opcode, A, B} vectors, compares the ALU's result and
// zero flag against an internal golden model, and reports a mismatch count,
// pass/fail and the first failing vector.
//
// Optional feature macro: ALU_TST_STOP_ON_FAIL_EN
//   defined   : the sweep ends at the CHECK that sees the first mismatch
//   undefined : the full 2048-vector sweep always runs
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   start-of-sweep request, honoured only in IDLE/DONE
//   dut_a        out  [3:0] operand A to the ALU (registered)
//   dut_b        out  [3:0] operand B to the ALU (registered)
//   dut_opcode   out  [2:0] opcode to the ALU (registered)
//   dut_result   in   [3:0] ALU result (ALU is combinational)
//   dut_zero     in   ALU zero flag
//   busy         out  sweep in progress
//   done         out  sweep finished; held until the next accepted start
//   pass         out  valid with done; 1 iff no vector failed
//   mismatch_cnt out  [CNT_W-1:0] failing vectors, saturating
//   vec_cnt      out  [CNT_W-1:0] vectors checked
//   ff_valid     out  first-fail capture valid
//   ff_opcode    out  [2:0] opcode of first failing vector
//   ff_a         out  [3:0] A of first failing vector
//   ff_b         out  [3:0] B of first failing vector
//   ff_result    out  [3:0] ALU result observed at first failure
//
// Parameters
//   SETTLE_CYCLES  cycles a vector is held in DRIVE before CHECK (min 1)
//   CNT_W          width of the mismatch and vector counters (>= 12)
// ---------------------------------------------------------------------------
module alu_mutation_tester #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    output logic [2:0]       dut_opcode,
    input  logic [3:0]       dut_result,
    input  logic             dut_zero,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] vec_cnt,
    output logic             ff_valid,
    output logic [2:0]       ff_opcode,
    output logic [3:0]       ff_a,
    output logic [3:0]       ff_b,
    output logic [3:0]       ff_result
);

    localparam int unsigned SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int unsigned SW          = $clog2(SETTLE_EFF + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_EFF);
    localparam logic [10:0]   LAST_VEC    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_e;

    // -----------------------------------------------------------------------
    // Golden 4-bit ALU
    // -----------------------------------------------------------------------
    function automatic logic [3:0] golden_alu(input logic [2:0] op,
                                              input logic [3:0] a,
                                              input logic [3:0] b);
        logic [3:0] r;
        r = '0;
        unique case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = {3'b000, (a == b)};
            3'b110:  r = {3'b000, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_e           state_q,  state_d;
    logic [10:0]      idx_q,    idx_d;      // {opcode, A, B}, B least significant
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] mism_q,   mism_d;
    logic [CNT_W-1:0] vec_q,    vec_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;
    logic             ffv_q,    ffv_d;
    logic [2:0]       ffop_q,   ffop_d;
    logic [3:0]       ffa_q,    ffa_d;
    logic [3:0]       ffb_q,    ffb_d;
    logic [3:0]       ffres_q,  ffres_d;

    // -----------------------------------------------------------------------
    // Response comparison for the vector currently driven
    // -----------------------------------------------------------------------
    logic [3:0]       gold_res;
    logic             gold_zero;
    logic             vec_fail;
    logic             stop_hit;
    logic [CNT_W-1:0] mism_sat_inc;

    always_comb begin
        gold_res     = golden_alu(idx_q[10:8], idx_q[7:4], idx_q[3:0]);
        gold_zero    = (gold_res == 4'd0);
        vec_fail     = (dut_result != gold_res) || (dut_zero != gold_zero);
        mism_sat_inc = (mism_q == '1) ? mism_q : mism_q + 1'b1;
    end

`ifdef ALU_TST_STOP_ON_FAIL_EN
    // Only the first mismatch of a sweep terminates it.
    assign stop_hit = vec_fail && !ffv_q;
`else
    assign stop_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        mism_d   = mism_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        ffv_d    = ffv_q;
        ffop_d   = ffop_q;
        ffa_d    = ffa_q;
        ffb_d    = ffb_q;
        ffres_d  = ffres_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_DRIVE;
                    idx_d    = '0;
                    // First vector settles one cycle longer than the rest:
                    // the counter starts at 0 here but at 1 after a CHECK.
                    settle_d = '0;
                    mism_d   = '0;
                    vec_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    ffv_d    = 1'b0;
                    ffop_d   = '0;
                    ffa_d    = '0;
                    ffb_d    = '0;
                    ffres_d  = '0;
                end
            end

            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            S_CHECK: begin
                vec_d = vec_q + 1'b1;
                if (vec_fail) begin
                    mism_d = mism_sat_inc;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffop_d  = idx_q[10:8];
                        ffa_d   = idx_q[7:4];
                        ffb_d   = idx_q[3:0];
                        ffres_d = dut_result;
                    end
                end
                if ((idx_q == LAST_VEC) || stop_hit) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mism_d == '0);
                end else begin
                    state_d  = S_DRIVE;
                    idx_d    = idx_q + 1'b1;
                    settle_d = SW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            mism_q   <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            ffv_q    <= 1'b0;
            ffop_q   <= '0;
            ffa_q    <= '0;
            ffb_q    <= '0;
            ffres_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            mism_q   <= mism_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            ffv_q    <= ffv_d;
            ffop_q   <= ffop_d;
            ffa_q    <= ffa_d;
            ffb_q    <= ffb_d;
            ffres_q  <= ffres_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -----------------------------------------------------------------------
    assign dut_opcode   = idx_q[10:8];
    assign dut_a        = idx_q[7:4];
    assign dut_b        = idx_q[3:0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mism_q;
    assign vec_cnt      = vec_q;
    assign ff_valid     = ffv_q;
    assign ff_opcode    = ffop_q;
    assign ff_a         = ffa_q;
    assign ff_b         = ffb_q;
    assign ff_result    = ffres_q;

endmodule

// File: tb/tb_alu_mutation_tester.sv
module tb_alu_mutation_tester;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    dut_a, dut_b, dut_result;
    logic [2:0]    dut_opcode;
    logic          dut_zero;
    logic          busy, done, pass;
    logic [CW-1:0] mismatch_cnt, vec_cnt;
    logic          ff_valid;
    logic [2:0]    ff_opcode;
    logic [3:0]    ff_a, ff_b, ff_result;

    // ALU variant under test: 0 fault-free, 1 opcode[1] stuck-at-1, 2 zero flag inverted
    int mode = 0;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    alu_mutation_tester #(
        .SETTLE_CYCLES(1),
        .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_opcode(dut_opcode),
        .dut_result(dut_result), .dut_zero(dut_zero),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .vec_cnt(vec_cnt),
        .ff_valid(ff_valid), .ff_opcode(ff_opcode),
        .ff_a(ff_a), .ff_b(ff_b), .ff_result(ff_result)
    );

    // ---------------- reference arithmetic ----------------
    function automatic int spec_res(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 16;
            1: return (a - b + 16) % 16;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a == b) ? 1 : 0;
            6: return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int alu_res(input int md, input int op, input int a, input int b);
        return (md == 1) ? spec_res(op | 2, a, b) : spec_res(op, a, b);
    endfunction

    function automatic bit alu_zero(input int md, input int op, input int a, input int b);
        return (md == 2) ? (alu_res(md, op, a, b) != 0) : (alu_res(md, op, a, b) == 0);
    endfunction

    // Combinational ALU variant attached to the tester
    always_comb begin
        dut_result = 4'(alu_res(mode, int'(dut_opcode), int'(dut_a), int'(dut_b)));
        dut_zero   = alu_zero(mode, int'(dut_opcode), int'(dut_a), int'(dut_b));
    end

    // ---------------- behavioural model of the tester ----------------
    // Sweep timeline (SETTLE_CYCLES=1): j cycles after the accepting edge,
    // (j-1)/2 vectors have been checked; the sweep ends after end_n vectors.
    int  cyc = 0;
    int  k_edge = 0;
    bit  m_on = 1'b0;
    int  pfx [0:2048];      // pfx[n] = failing vectors among the first n
    int  first_fail = -1;
    int  ff_res_m = 0;
    int  end_n = 2048;
    int  m_jold;
    bit  m_wasdone;

    function automatic int nv_of(input int j);
        int n;
        if (j <= 0) return 0;
        n = (j - 1) / 2;
        if (n > end_n) n = end_n;
        return n;
    endfunction

    task automatic build(input int md);
        int op, a, b;
        bit f;
        pfx[0] = 0;
        first_fail = -1;
        ff_res_m = 0;
        for (int v = 0; v < 2048; v++) begin
            op = v / 256; a = (v / 16) % 16; b = v % 16;
            f = (alu_res(md, op, a, b) != spec_res(op, a, b)) ||
                (alu_zero(md, op, a, b) != (spec_res(op, a, b) == 0));
            pfx[v+1] = pfx[v] + (f ? 1 : 0);
            if (f && first_fail < 0) begin
                first_fail = v;
                ff_res_m = alu_res(md, op, a, b);
            end
        end
        end_n = 2048;
`ifdef ALU_TST_STOP_ON_FAIL_EN
        if (first_fail >= 0) end_n = first_fail + 1;
`endif
    endtask

    always @(posedge clk) begin
        m_jold    = cyc - k_edge;
        m_wasdone = m_on && (nv_of(m_jold) >= end_n);
        cyc = cyc + 1;
        if (!rst_n) begin
            m_on = 1'b0;
        end else if (start && (!m_on || m_wasdone)) begin
            m_on   = 1'b1;
            k_edge = cyc;
            build(mode);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic step();
        int  nv, idx, mexp, ffexp;
        bit  dn, pexp, ffv;
        @(negedge clk);
        if (!cmp_en) return;
        if (!m_on) begin
            nv = 0; idx = 0; mexp = 0; ffexp = 0; dn = 0; pexp = 0; ffv = 0;
            chk("ctrl", int'({busy, done, pass, ff_valid}), 0);
        end else begin
            nv   = nv_of(cyc - k_edge);
            dn   = (nv >= end_n);
            idx  = dn ? end_n - 1 : nv;
            mexp = (pfx[nv] > 4095) ? 4095 : pfx[nv];
            ffv  = (pfx[nv] > 0);
            pexp = dn && (pfx[end_n] == 0);
            ffexp = ffv ? (first_fail * 16 + ff_res_m) : 0;
            chk("ctrl", int'({busy, done, pass, ff_valid}), int'({~dn, dn, pexp, ffv}));
        end
        chk("vec_cnt", int'(vec_cnt), nv);
        chk("mismatch_cnt", int'(mismatch_cnt), mexp);
        chk("vector", int'({dut_opcode, dut_a, dut_b}), idx);
        chk("first_fail", int'({ff_opcode, ff_a, ff_b, ff_result}), ffexp);
    endtask

    task automatic run_sweep(input int md, input bit hold, output int lat);
        int cnt;
        mode  = md;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        cnt = 1;
        while (!done && cnt < 6000) begin
            step();
            cnt++;
        end
        chk("done_reached", int'(done), 1);
        lat = cnt - 1;
    endtask

    task automatic reset_zero_checks(input string tag);
        chk({tag, "_busy_done"}, int'({busy, done, pass}), 0);
        chk({tag, "_counts"}, int'(vec_cnt) + int'(mismatch_cnt), 0);
        chk({tag, "_vector"}, int'({dut_opcode, dut_a, dut_b}), 0);
        chk({tag, "_ff"}, int'({ff_valid, ff_opcode, ff_a, ff_b, ff_result}), 0);
    endtask

    initial begin
        int lat, cnt, r;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        step();
        reset_zero_checks("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // fault-free sweep
        run_sweep(0, 1'b0, lat);
        chk("ok_latency", lat, 4097);
        chk("ok_pass", int'(pass), 1);
        chk("ok_mismatch", int'(mismatch_cnt), 0);
        chk("ok_vec_cnt", int'(vec_cnt), 2048);
        chk("ok_ff_valid", int'(ff_valid), 0);

        // opcode[1] stuck-at-1
        run_sweep(1, 1'b0, lat);
        chk("sa1_pass", int'(pass), 0);
        chk("sa1_ff_valid", int'(ff_valid), 1);
        chk("sa1_ff_vec", int'({ff_opcode, ff_a, ff_b}), 1);
        chk("sa1_ff_result", int'(ff_result), 0);
`ifdef ALU_TST_STOP_ON_FAIL_EN
        chk("sa1_vec_cnt", int'(vec_cnt), 2);
        chk("sa1_mismatch", int'(mismatch_cnt), 1);
`else
        chk("sa1_mismatch", int'(mismatch_cnt), pfx[2048]);
        chk("sa1_vec_cnt", int'(vec_cnt), 2048);
`endif

        // zero flag inverted on every vector
        run_sweep(2, 1'b0, lat);
        chk("zinv_pass", int'(pass), 0);
        chk("zinv_ff", int'({ff_valid, ff_opcode, ff_a, ff_b, ff_result}), 32'h8000);
`ifdef ALU_TST_STOP_ON_FAIL_EN
        chk("zinv_mismatch", int'(mismatch_cnt), 1);
`else
        chk("zinv_mismatch", int'(mismatch_cnt), 2048);
`endif

        // reset mid-sweep at vec_cnt = 100
        mode  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (int'(vec_cnt) != 100 && cnt < 400) begin step(); cnt++; end
        chk("abort_reached", int'(vec_cnt), 100);
        rst_n = 1'b0;
        step();
        reset_zero_checks("abort");
        rst_n = 1'b1;
        step();
        run_sweep(0, 1'b0, lat);
        chk("fresh_pass", int'(pass), 1);
        chk("fresh_vec_cnt", int'(vec_cnt), 2048);

        // start held high through the sweep, then restart from DONE
        run_sweep(0, 1'b1, lat);
        chk("held_latency", lat, 4097);
        step();
        chk("held_restart", int'({busy, done}), 2);
        chk("held_restart_cnt", int'(vec_cnt), 0);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 6000) begin step(); cnt++; end
        chk("held_done2", int'(done), 1);
        chk("held_pass2", int'(pass), 1);

        // randomized: random ALU variant with start noise during the sweep
        repeat (3) begin
            mode  = int'($urandom_range(0, 2));
            start = 1'b1;
            step();
            start = 1'b0;
            cnt = 0;
            while (cnt < 6000) begin
                step();
                cnt++;
                if (done) break;
                start = (int'(vec_cnt) < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            start = 1'b0;
            chk("rand_done", int'(done), 1);
            chk("rand_pass", int'(pass), (pfx[end_n] == 0) ? 1 : 0);
        end

        // randomized abort point
        mode = 0;
        r = int'($urandom_range(1, 1500));
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (int'(vec_cnt) != r && cnt < 4000) begin step(); cnt++; end
        chk("rand_abort_reached", int'(vec_cnt), r);
        rst_n = 1'b0;
        step();
        reset_zero_checks("rand_abort");
        rst_n = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_mutation_tester.md
Name: alu_mutation_tester

Overview:
Self-checking stimulus/response engine that drives the 4-bit ALU under test (golden or mutated) and checks it.
- Sweeps all 2048 {opcode, A, B} vectors.
- Compares the DUT's result and zero flag against an internal golden ALU model.
- Reports mismatch count, pass/fail and the first failing vector.
- Sits beside any 4-bit ALU variant in the mutation-testing bench, as the initiator side of the ALU's operand/result interface.

Parameters:
- SETTLE_CYCLES, 1, cycles that the DRIVE state holds the vector before CHECK (minimum 1)
- CNT_W, 12, width of the mismatch and vector counters (must hold 2048)

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  start-of-sweep request, sampled in IDLE/DONE
- dut_a  output  4  operand A to the DUT, registered
- dut_b  output  4  operand B to the DUT, registered
- dut_opcode  output  3  opcode to the DUT, registered
- dut_result  input  4  DUT result (DUT is combinational)
- dut_zero  input  1  DUT zero flag
- busy  output  1  sweep in progress
- done  output  1  sweep finished; held until next accepted start
- pass  output  1  valid when done=1; 1 iff mismatch_cnt==0
- mismatch_cnt  output  CNT_W  vectors that failed, saturating
- vec_cnt  output  CNT_W  vectors checked
- ff_valid  output  1  first-fail capture valid
- ff_opcode  output  3  opcode of first failing vector
- ff_a  output  4  A of first failing vector
- ff_b  output  4  B of first failing vector
- ff_result  output  4  DUT result observed at first fail

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0, including dut_* and counters. Reset mid-sweep aborts immediately with no partial results retained.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE/DONE, start=1:
  - vector index ← 0; dut_opcode/dut_a/dut_b ← 0.
  - mismatch_cnt, vec_cnt, ff_* ← 0; done ← 0, pass ← 0; busy ← 1.
  - Next state DRIVE.
- start in DRIVE/CHECK is ignored.
- DRIVE: hold the vector for SETTLE_CYCLES cycles (internal settle counter), then go to CHECK.
- CHECK: sample dut_result/dut_zero; compute golden(vector); vec_cnt+1.
  - Mismatch if result or zero differs: mismatch_cnt+1, saturating at all-ones.
  - On mismatch with ff_valid=0: capture ff_* and set ff_valid=1.
  - If vector index = 2047: go to DONE. Otherwise index+1, drive the new vector registers and return to DRIVE.
- Vector index is 11 bits = {opcode[2:0], A[3:0], B[3:0]}; B is least significant. dut_* always reflect the current index.
- DONE: busy=0, done=1, pass=(mismatch_cnt==0). dut_* hold the last vector. All results are held until the next accepted start.
- Golden model (4-bit, mod 16):
  - 000 A+B; 001 A−B; 010 A&B; 011 A|B; 100 A^B.
  - 101 (A==B)?1:0; 110 unsigned (A<B)?1:0; 111 → 0.
  - Golden zero = (golden result == 0).
- Latency with start sampled at edge k: DONE entered at edge k+1+2048·(SETTLE_CYCLES+1), which is k+4097 for default parameters.

Optional Feature:
ALU_TST_STOP_ON_FAIL_EN
- Defined: the CHECK that detects the first mismatch goes directly to DONE. vec_cnt = vectors checked including the failing one; mismatch_cnt=1; pass=0.
- Undefined: the full 2048-vector sweep always runs.

Test Plan:
- Fault-free ALU DUT, pulse start → busy for the sweep; done=1 at start-edge+4097; pass=1; mismatch_cnt=0; vec_cnt=2048; ff_valid=0.
- Opcode[1] stuck-at-1 mutant → pass=0; ff_valid=1; ff_opcode=000, ff_a=0, ff_b=1, ff_result=0 (AND instead of ADD). mismatch_cnt equals the bench's reference count.
- Bench model forces dut_zero inverted on every vector → mismatch_cnt=2048; ff at vector 0 (op 000, A=0, B=0).
- rst_n=0 asserted at vec_cnt=100 → next cycle all outputs 0 and state IDLE; a new start gives a complete fresh sweep with pass=1 on a fault-free DUT.
- start held high throughout the sweep → no restart mid-sweep. After DONE, start still high restarts: done←0 and counters cleared the next cycle.
- With ALU_TST_STOP_ON_FAIL_EN defined, stuck-at mutant → done with vec_cnt=2, mismatch_cnt=1, ff_b=1.
